// File: rtl/avm_rd_arb.sv
// avm_rd_arb -- two-requester burst-read arbiter onto one Avalon-MM read port.
//
// Purpose:
//   Requesters 0 and 1 issue burst reads. A round-robin arbiter picks one,
//   registers its command and holds it on the DDR port until the DDR accepts
//   it. A tag FIFO records {requester id, burstcount} per accepted command.
//   Returning beats are routed to the requester at the FIFO head, and that
//   entry is retired when its last beat arrives. The DDR returns data in
//   command order.
//
// Handshake semantics (Avalon-MM, all signals sampled on rising exclk):
//   A command transfers on the cycle where read is high and waitrequest is
//   low. While waitrequest is high, the master holds read, address and
//   burstcount stable. reqN_waitrequest is low only in the cycle that
//   requester N's command is accepted by the DDR. readdatavalid marks one
//   64-bit return beat per cycle.
//
// Ports:
//   exclk, rst_n          clock, asynchronous active-low reset
//   reqN_read/address/burstcount   requester N command (N = 0, 1)
//   reqN_waitrequest      requester N stall (high except on acceptance)
//   reqN_readdata/valid   requester N return data and beat valid
//   r_avm_*               DDR Avalon-MM read master port
//   err_unexpected        sticky: a beat arrived with nothing outstanding
//   dbg_state             current FSM state (0 = IDLE, 1 = ISSUE)

module avm_rd_arb #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        exclk,
  input  logic        rst_n,

  input  logic        req0_read,
  input  logic [31:0] req0_address,
  input  logic [4:0]  req0_burstcount,
  output logic        req0_waitrequest,
  output logic [63:0] req0_readdata,
  output logic        req0_readdatavalid,

  input  logic        req1_read,
  input  logic [31:0] req1_address,
  input  logic [4:0]  req1_burstcount,
  output logic        req1_waitrequest,
  output logic [63:0] req1_readdata,
  output logic        req1_readdatavalid,

  input  logic        r_avm_waitrequest,
  output logic        r_avm_read,
  output logic [31:0] r_avm_address,
  output logic [4:0]  r_avm_burstcount,
  output logic [7:0]  r_avm_byteenable,
  input  logic [63:0] r_avm_readdata,
  input  logic        r_avm_readdatavalid,

  output logic        err_unexpected,
  output logic        dbg_state
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] addr_q;
  logic [4:0]  bc_q;
  logic        grant_id_q;
  logic        last_grant_q;

  // Tag FIFO: id and burstcount per accepted, not yet completed burst.
  logic        tag_id [TAG_DEPTH];
  logic [4:0]  tag_bc [TAG_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [4:0]    beat_cnt_q;

  logic        fifo_full, fifo_empty;
  logic        any_req, win_id, grant;
  logic [31:0] win_addr;
  logic [4:0]  win_bc;
  logic        accept;
  logic        head_id;
  logic [4:0]  head_bc;
  logic        beat, last_beat;

  // Zero-length bursts are not legal on Avalon; issue them as single beats.
  function automatic logic [4:0] clamp_bc(input logic [4:0] b);
    if (b == 5'd0)       return 5'd1;
    else if (b > 5'd16)  return 5'd16;
    else                 return b;
  endfunction

  assign fifo_full  = (count_q == (PW+1)'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign any_req = req0_read | req1_read;
  // On contention the requester not granted last wins; otherwise the only one.
  assign win_id   = (req0_read & req1_read) ? ~last_grant_q : req1_read;
  assign win_addr = win_id ? req1_address : req0_address;
  assign win_bc   = clamp_bc(win_id ? req1_burstcount : req0_burstcount);

  assign grant  = (state_q == IDLE) && !fifo_full && any_req;
  assign accept = (state_q == ISSUE) && !r_avm_waitrequest;

  assign head_id = tag_id[rd_ptr_q];
  assign head_bc = tag_bc[rd_ptr_q];

  // Beats with nothing outstanding are flagged, never forwarded or counted.
  assign beat      = r_avm_readdatavalid && !fifo_empty;
  assign last_beat = beat && (5'(beat_cnt_q + 5'd1) == head_bc);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)  state_d = ISSUE;
      ISSUE:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge exclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      bc_q         <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant) begin
        addr_q       <= win_addr;
        bc_q         <= win_bc;
        grant_id_q   <= win_id;
        last_grant_q <= win_id;
      end
    end
  end

  always_ff @(posedge exclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      beat_cnt_q     <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (accept)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (last_beat) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({accept, last_beat})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (last_beat)  beat_cnt_q <= '0;
      else if (beat)  beat_cnt_q <= beat_cnt_q + 5'd1;
      if (r_avm_readdatavalid && fifo_empty) err_unexpected <= 1'b1;
    end
  end

  // Entries are only read while valid, so storage needs no reset.
  always_ff @(posedge exclk) begin
    if (accept) begin
      tag_id[wr_ptr_q] <= grant_id_q;
      tag_bc[wr_ptr_q] <= bc_q;
    end
  end

  assign r_avm_read       = (state_q == ISSUE);
  assign r_avm_address    = addr_q;
  assign r_avm_burstcount = bc_q;
  assign r_avm_byteenable = 8'hFF;

  assign req0_waitrequest = !(accept && (grant_id_q == 1'b0));
  assign req1_waitrequest = !(accept && (grant_id_q == 1'b1));

  assign req0_readdata = r_avm_readdata;
  assign req1_readdata = r_avm_readdata;

  assign req0_readdatavalid = beat && (head_id == 1'b0);
  assign req1_readdatavalid = beat && (head_id == 1'b1);

  assign dbg_state = state_q;

endmodule

// File: doc/avm_rd_arb.md
AVM_RD_ARB -- requirements
Module: avm_rd_arb

Interface
REQ-001 The block SHALL have parameter TAG_DEPTH, default 4, meaning the maximum number of accepted-but-incomplete bursts (power of 2, 2..16).
REQ-002 The block SHALL have the following ports:
  exclk  in  1  sole clock, all logic rising-edge.
  rst_n  in  1  asynchronous active-low reset.
  req0_read  in  1  requester 0 burst-read request.
  req0_address  in  32  requester 0 byte address.
  req0_burstcount  in  5  requester 0 beats (64-bit).
  req0_waitrequest  out  1  requester 0 stall.
  req0_readdata  out  64  requester 0 return data.
  req0_readdatavalid  out  1  requester 0 beat valid.
  req1_*  same set as req0_*, for requester 1.
  r_avm_waitrequest  in  1  DDR stall.
  r_avm_read  out  1  DDR read command.
  r_avm_address  out  32  DDR address.
  r_avm_burstcount  out  5  DDR burst length.
  r_avm_byteenable  out  8  DDR byte enable.
  r_avm_readdata  in  64  DDR return data.
  r_avm_readdatavalid  in  1  DDR beat valid.
  err_unexpected  out  1  sticky: a beat arrived with no burst outstanding.

Function
REQ-003 The FSM SHALL have two states: IDLE (no command on DDR) and ISSUE (registered command held on DDR).
REQ-004 In IDLE, with tag FIFO not full and any reqN_read high, the block SHALL register the winner's address and burstcount and enter ISSUE next cycle (r_avm_read high 1 cycle after request).
REQ-005 Arbitration SHALL be round-robin: on a simultaneous request, the requester not granted last wins; after reset, requester 0 wins first.
REQ-006 In ISSUE, r_avm_read, r_avm_address and r_avm_burstcount SHALL hold stable while r_avm_waitrequest is high.
REQ-007 In ISSUE with r_avm_waitrequest low, the command SHALL be accepted: push {id, burstcount} into the tag FIFO and return to IDLE.
REQ-008 reqN_waitrequest SHALL be low only in the acceptance cycle of requester N's command; it SHALL be high at all other times, including during reset.
REQ-009 Requesters SHALL hold read, address and burstcount stable while their waitrequest is high.
REQ-010 A burstcount of 0 SHALL be issued as 1; values 1..16 SHALL pass unchanged; values above 16 SHALL be clamped to 16.
REQ-011 r_avm_byteenable SHALL be constant 8'hFF.
REQ-012 req0_readdata and req1_readdata SHALL both equal r_avm_readdata combinationally.
REQ-013 reqN_readdatavalid SHALL equal r_avm_readdatavalid AND (FIFO head id == N) AND FIFO not empty.
REQ-014 A beat counter SHALL count valid beats; on the beat equal to the head burstcount it SHALL pop the FIFO and clear to 0.
REQ-015 A push and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-016 With the FIFO full (TAG_DEPTH outstanding), no new grant SHALL occur; arbitration SHALL resume the cycle after a pop.
REQ-017 A beat arriving while the FIFO is empty SHALL set err_unexpected (cleared only by reset), SHALL NOT be forwarded, and SHALL NOT alter the counter.
REQ-018 DDR returns SHALL be treated as in command-acceptance order; there SHALL be no reordering.

Reset
REQ-019 While rst_n is low: state=IDLE, FIFO empty, beat counter 0, last-grant=1, r_avm_read=0, r_avm_address=0, r_avm_burstcount=0, err_unexpected=0, both reqN_waitrequest=1, both reqN_readdatavalid=0.
REQ-020 Reset asserted mid-command or mid-burst SHALL discard all outstanding tags immediately; beats arriving after release SHALL set err_unexpected.

Verification
REQ-021 Single read: req0 addr 0x1000, burst 4, waitrequest low -> r_avm_read one cycle later; req0_waitrequest low one cycle; 4 beats on req0_readdatavalid only.
REQ-022 Contention: req0 and req1 both request every cycle from reset -> grants alternate 0,1,0,1; returns routed to the matching requester.
REQ-023 Backpressure: r_avm_waitrequest high for 5 cycles during ISSUE -> address and burstcount stable; exactly one push on release.
REQ-024 Full FIFO: TAG_DEPTH=4, 4 bursts of 2 accepted, no returns -> 5th request stalls; first beat pair returned -> grant the next cycle.
REQ-025 Boundaries: burstcount 0 -> issued 1; burstcount 20 -> issued 16; beat with empty FIFO -> err_unexpected=1 and no readdatavalid.
REQ-026 rst_n pulsed low mid-burst (2 of 8 beats returned) -> all outputs at reset values; next request is served normally.
